// File: rtl/burst_wf_pkg.sv
// Shared constants, FSM state types and the burst offset helper for the burst copy engine.
package burst_wf_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH          = 32;
  localparam int unsigned DEF_LENGTH_WIDTH           = 32;
  localparam int unsigned DEF_DATA_WIDTH             = 32;
  localparam int unsigned DEF_BYTE_ENABLE_WIDTH      = 4;
  localparam int unsigned DEF_BYTE_ENABLE_WIDTH_LOG2 = 2;
  localparam int unsigned DEF_BURST_COUNT            = 8;
  localparam int unsigned DEF_BURST_WIDTH            = 4;

  typedef enum logic [1:0] {RdIdle, RdReq, RdData} rd_state_t;
  typedef enum logic       {WrIdle, WrWrite}        wr_state_t;

  // Byte offset of burst idx: idx * burst_count words, each 2**be_log2 bytes wide.
  function automatic logic [63:0] burst_offset(input logic [31:0] idx,
                                               input int unsigned burst_count,
                                               input int unsigned be_log2);
    return (64'(idx) * 64'(burst_count)) << be_log2;
  endfunction

endpackage

// File: rtl/burst_fifo_wf.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry while not empty.
module burst_fifo_wf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/burst_read_write_wf.sv
// Avalon-MM burst copy engine: reads one burst into a FIFO and writes it back out at the
// same burst offset in the write region.
module burst_read_write_wf
  import burst_wf_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH          = DEF_ADDRESS_WIDTH,
  parameter int unsigned LENGTH_WIDTH           = DEF_LENGTH_WIDTH,
  parameter int unsigned DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int unsigned BYTE_ENABLE_WIDTH      = DEF_BYTE_ENABLE_WIDTH,
  parameter int unsigned BYTE_ENABLE_WIDTH_LOG2 = DEF_BYTE_ENABLE_WIDTH_LOG2,
  parameter int unsigned BURST_COUNT            = DEF_BURST_COUNT,
  parameter int unsigned BURST_WIDTH            = DEF_BURST_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]     ctrl_rd_baseaddress,
  input  logic [ADDRESS_WIDTH-1:0]     ctrl_wr_baseaddress,
  input  logic [BURST_WIDTH-1:0]       ctrl_burstcount,
  output logic                         ctrl_busy,
  output logic [BURST_WIDTH-1:0]       ctrl_address,
  output logic [ADDRESS_WIDTH-1:0]     rd_address,
  output logic                         rd_read,
  output logic [BURST_WIDTH-1:0]       rd_burstcount,
  input  logic                         rd_waitrequest,
  input  logic                         rd_readdatavalid,
  input  logic [DATA_WIDTH-1:0]        rd_readdata,
  output logic [ADDRESS_WIDTH-1:0]     wr_address,
  output logic                         wr_write,
  output logic [DATA_WIDTH-1:0]        wr_writedata,
  output logic [BURST_WIDTH-1:0]       wr_burstcount,
  output logic [BYTE_ENABLE_WIDTH-1:0] wr_byteenable,
  input  logic                         wr_waitrequest
);

  localparam int unsigned FifoDepth = 2 * BURST_COUNT;

  rd_state_t                rd_state_q, rd_state_d;
  wr_state_t                wr_state_q, wr_state_d;
  logic                     rd_read_q, rd_read_d;
  logic [ADDRESS_WIDTH-1:0] rd_address_q, rd_address_d, wr_address_q, wr_address_d;
  logic [BURST_WIDTH-1:0]   rd_burstcount_q, rd_burstcount_d, wr_burstcount_q, wr_burstcount_d;
  logic [BURST_WIDTH-1:0]   ctrl_address_q, ctrl_address_d;
  logic [LENGTH_WIDTH-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  logic                     fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0]    fifo_head;
  logic [$clog2(FifoDepth+1)-1:0] fifo_count;
  logic                     unused_fifo;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [BURST_WIDTH-1:0]   burst_len;
  logic                     wr_accept;

  assign offset = ADDRESS_WIDTH'(burst_offset(32'(ctrl_address_q), BURST_COUNT,
                                               BYTE_ENABLE_WIDTH_LOG2));
  assign burst_len = (ctrl_burstcount > BURST_WIDTH'(BURST_COUNT)) ?
                     BURST_WIDTH'(BURST_COUNT) : ctrl_burstcount;

  assign ctrl_busy     = (rd_state_q != RdIdle) | (wr_state_q != WrIdle);
  assign ctrl_address  = ctrl_address_q;
  assign rd_read       = rd_read_q;
  assign rd_address    = rd_address_q;
  assign rd_burstcount = rd_burstcount_q;
  assign wr_address    = wr_address_q;
  assign wr_burstcount = wr_burstcount_q;
  assign wr_write      = (wr_state_q == WrWrite) & ~fifo_empty;
  assign wr_writedata  = wr_write ? fifo_head : '0;
  assign wr_byteenable = {BYTE_ENABLE_WIDTH{wr_write}};
  assign wr_accept     = wr_write & ~wr_waitrequest;
  assign unused_fifo   = ^{fifo_full, fifo_count};

  always_comb begin
    rd_state_d      = rd_state_q;
    rd_read_d       = rd_read_q;
    rd_address_d    = rd_address_q;
    rd_burstcount_d = rd_burstcount_q;
    rd_cnt_d        = rd_cnt_q;
    wr_state_d      = wr_state_q;
    wr_address_d    = wr_address_q;
    wr_burstcount_d = wr_burstcount_q;
    wr_cnt_d        = wr_cnt_q;
    ctrl_address_d  = ctrl_address_q;
    fifo_push       = 1'b0;
    fifo_pop        = 1'b0;

    case (rd_state_q)
      RdIdle: begin
        if (ctrl_start && !ctrl_busy && (burst_len != '0)) begin
          rd_state_d      = RdReq;
          rd_read_d       = 1'b1;
          rd_address_d    = ctrl_rd_baseaddress + offset;
          rd_burstcount_d = burst_len;
          rd_cnt_d        = '0;
        end
      end
      RdReq: begin
        if (!rd_waitrequest) begin
          rd_state_d = RdData;
          rd_read_d  = 1'b0;
        end
      end
      RdData: begin
        if (rd_readdatavalid) begin
          fifo_push = 1'b1;
          rd_cnt_d  = rd_cnt_q + LENGTH_WIDTH'(1);
          if ((rd_cnt_q + LENGTH_WIDTH'(1)) == LENGTH_WIDTH'(rd_burstcount_q)) begin
            rd_state_d = RdIdle;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase

    // The write side opens its burst on the first beat pushed into the FIFO.
    case (wr_state_q)
      WrIdle: begin
        if (fifo_push) begin
          wr_state_d      = WrWrite;
          wr_address_d    = ctrl_wr_baseaddress + offset;
          wr_burstcount_d = rd_burstcount_q;
          wr_cnt_d        = '0;
        end
      end
      WrWrite: begin
        if (wr_accept) begin
          fifo_pop = 1'b1;
          wr_cnt_d = wr_cnt_q + LENGTH_WIDTH'(1);
          if ((wr_cnt_q + LENGTH_WIDTH'(1)) == LENGTH_WIDTH'(wr_burstcount_q)) begin
            wr_state_d     = WrIdle;
            ctrl_address_d = ctrl_address_q + BURST_WIDTH'(1);
          end
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q      <= RdIdle;
      wr_state_q      <= WrIdle;
      rd_read_q       <= 1'b0;
      rd_address_q    <= '0;
      rd_burstcount_q <= '0;
      rd_cnt_q        <= '0;
      wr_address_q    <= '0;
      wr_burstcount_q <= '0;
      wr_cnt_q        <= '0;
      ctrl_address_q  <= '0;
    end else begin
      rd_state_q      <= rd_state_d;
      wr_state_q      <= wr_state_d;
      rd_read_q       <= rd_read_d;
      rd_address_q    <= rd_address_d;
      rd_burstcount_q <= rd_burstcount_d;
      rd_cnt_q        <= rd_cnt_d;
      wr_address_q    <= wr_address_d;
      wr_burstcount_q <= wr_burstcount_d;
      wr_cnt_q        <= wr_cnt_d;
      ctrl_address_q  <= ctrl_address_d;
    end
  end

  burst_fifo_wf #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rd_readdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_burst_read_write_wf.sv
// Bench for burst_read_write_wf: cycle-level Avalon slave models plus a transaction-level
// expectation of which words must appear where.
module tb_burst_read_write_wf;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned BC = 8;

  logic          clk = 1'b0;
  logic          reset, ctrl_start, ctrl_busy;
  logic [AW-1:0] ctrl_rd_baseaddress, ctrl_wr_baseaddress, rd_address, wr_address;
  logic [BW-1:0] ctrl_burstcount, ctrl_address, rd_burstcount, wr_burstcount;
  logic          rd_read, rd_waitrequest, rd_readdatavalid, wr_write, wr_waitrequest;
  logic [DW-1:0] rd_readdata, wr_writedata;
  logic [3:0]    wr_byteenable;

  always #5 clk = ~clk;

  burst_read_write_wf dut (
    .clk                 (clk),
    .reset               (reset),
    .ctrl_start          (ctrl_start),
    .ctrl_rd_baseaddress (ctrl_rd_baseaddress),
    .ctrl_wr_baseaddress (ctrl_wr_baseaddress),
    .ctrl_burstcount     (ctrl_burstcount),
    .ctrl_busy           (ctrl_busy),
    .ctrl_address        (ctrl_address),
    .rd_address          (rd_address),
    .rd_read             (rd_read),
    .rd_burstcount       (rd_burstcount),
    .rd_waitrequest      (rd_waitrequest),
    .rd_readdatavalid    (rd_readdatavalid),
    .rd_readdata         (rd_readdata),
    .wr_address          (wr_address),
    .wr_write            (wr_write),
    .wr_writedata        (wr_writedata),
    .wr_burstcount       (wr_burstcount),
    .wr_byteenable       (wr_byteenable),
    .wr_waitrequest      (wr_waitrequest)
  );

  int total = 0;
  int bad   = 0;

  // Transaction model: words returned by the read slave, owed to the write slave in order.
  logic [DW-1:0] exp_q[$];
  int unsigned   model_idx;
  int            beats_left, lat, cur_len, wr_done, bursts_done, beat_no;
  bit            rd_pending, expect_req, prev_wr_stall;
  logic [AW-1:0] exp_rd_addr;

  int rd_wait_pct, wr_wait_pct, gap_pct;
  bit seq_data, spurious;
  bit rd_wait_pat[$];
  bit wr_wait_pat[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_len(input int bc);
    return (bc > int'(BC)) ? int'(BC) : bc;
  endfunction

  function automatic logic [AW-1:0] burst_addr(input logic [AW-1:0] base);
    return base + AW'((model_idx % 16) * BC * 4);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    model_idx     = 0;
    beats_left    = 0;
    lat           = 0;
    cur_len       = 0;
    wr_done       = 0;
    rd_pending    = 0;
    expect_req    = 0;
    prev_wr_stall = 0;
  endtask

  // Called #1 after a rising edge: check outputs, choose this cycle's inputs, advance.
  task automatic tick();
    bit new_req, busy_exp, w;
    new_req  = (rd_read === 1'b1) && !rd_pending;
    busy_exp = rd_pending || new_req || (beats_left > 0) || (exp_q.size() > 0) || (wr_done > 0);
    chk("ctrl_address", ctrl_address, model_idx % 16);
    chk("ctrl_busy", ctrl_busy, busy_exp);
    chk("rd_start_timing", new_req, expect_req);
    if (rd_pending)    chk("rd_read_hold", rd_read, 1);
    if (prev_wr_stall) chk("wr_write_hold", wr_write, 1);

    rd_readdatavalid = 1'b0;
    rd_readdata      = $urandom;
    if (beats_left > 0) begin
      if (lat > 0) lat--;
      else if ($urandom_range(99) >= gap_pct) begin
        rd_readdatavalid = 1'b1;
        if (seq_data) rd_readdata = DW'(beat_no);
        exp_q.push_back(rd_readdata);
        beat_no++;
        beats_left--;
      end
    end else if (spurious && !rd_pending) begin
      rd_readdatavalid = 1'($urandom_range(1));
    end

    rd_waitrequest = 1'($urandom_range(1));
    if (new_req) begin
      exp_rd_addr = burst_addr(ctrl_rd_baseaddress);
      cur_len     = clamp_len(int'(ctrl_burstcount));
      rd_pending  = 1;
    end
    if (rd_pending) begin
      chk("rd_address", rd_address, exp_rd_addr);
      chk("rd_burstcount", rd_burstcount, cur_len);
      if (rd_wait_pat.size() > 0) w = rd_wait_pat.pop_front();
      else w = ($urandom_range(99) < rd_wait_pct);
      rd_waitrequest = w;
      if (!w) begin
        rd_pending = 0;
        beats_left = cur_len;
        lat        = $urandom_range(2);
        beat_no    = 0;
      end
    end

    prev_wr_stall  = 0;
    wr_waitrequest = 1'($urandom_range(1));
    if (wr_write === 1'b1) begin
      chk("wr_byteenable", wr_byteenable, 4'hF);
      chk("wr_address", wr_address, burst_addr(ctrl_wr_baseaddress));
      chk("wr_burstcount", wr_burstcount, cur_len);
      if (exp_q.size() == 0) begin
        chk("wr_unexpected_beat", exp_q.size(), 1);
      end else begin
        chk("wr_writedata", wr_writedata, exp_q[0]);
        if (wr_wait_pat.size() > 0) w = wr_wait_pat.pop_front();
        else w = ($urandom_range(99) < wr_wait_pct);
        wr_waitrequest = w;
        if (w) prev_wr_stall = 1;
        else begin
          void'(exp_q.pop_front());
          wr_done++;
          if (wr_done == cur_len) begin
            wr_done = 0;
            model_idx++;
            bursts_done++;
          end
        end
      end
    end else begin
      chk("wr_byteenable_idle", wr_byteenable, 0);
    end

    expect_req = ctrl_start && (ctrl_burstcount != '0) && !busy_exp;
    @(posedge clk);
    #1;
  endtask

  task automatic run_bursts(input int n);
    int target, cyc;
    target = bursts_done + n;
    cyc    = 0;
    while (bursts_done < target && cyc < 400 * n) begin
      tick();
      cyc++;
    end
    chk("bursts_completed", bursts_done, target);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    ctrl_start       = 1'b0;
    rd_readdatavalid = 1'b0;
    rd_waitrequest   = 1'b0;
    wr_waitrequest   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rd_read", rd_read, 0);
    chk("rst_rd_address", rd_address, 0);
    chk("rst_rd_burstcount", rd_burstcount, 0);
    chk("rst_wr_write", wr_write, 0);
    chk("rst_wr_address", wr_address, 0);
    chk("rst_wr_burstcount", wr_burstcount, 0);
    chk("rst_wr_byteenable", wr_byteenable, 0);
    chk("rst_wr_writedata", wr_writedata, 0);
    chk("rst_ctrl_busy", ctrl_busy, 0);
    chk("rst_ctrl_address", ctrl_address, 0);
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    int cyc;
    reset               = 1'b1;
    ctrl_start          = 1'b0;
    ctrl_rd_baseaddress = 32'h3800_0000;
    ctrl_wr_baseaddress = 32'h3800_0000;
    ctrl_burstcount     = 4'd8;
    rd_readdata         = '0;
    rd_wait_pct = 0; wr_wait_pct = 0; gap_pct = 20;
    seq_data = 1; spurious = 0; bursts_done = 0;
    do_reset();

    // Four back-to-back bursts with directed read and write stalls.
    rd_wait_pat = '{1, 1, 0};
    wr_wait_pat = '{0, 0, 1, 1, 1, 0};
    ctrl_start  = 1'b1;
    run_bursts(4);

    // Random stalls and data, past the 15 -> 0 index wrap.
    rd_wait_pct = 30; wr_wait_pct = 30; gap_pct = 30; seq_data = 0;
    run_bursts(14);
    ctrl_start = 1'b0;

    // Zero burst count never starts; beats while idle must be dropped.
    ctrl_burstcount = 4'd0;
    ctrl_start      = 1'b1;
    spurious        = 1;
    repeat (20) tick();
    spurious   = 0;
    ctrl_start = 1'b0;
    tick();

    // Oversize burst count clamps to the maximum.
    ctrl_burstcount = 4'd12;
    ctrl_start      = 1'b1;
    run_bursts(2);
    ctrl_start = 1'b0;

    // Random lengths and bases, one burst each.
    for (int i = 0; i < 6; i++) begin
      ctrl_burstcount     = BW'($urandom_range(1, 15));
      ctrl_rd_baseaddress = $urandom;
      ctrl_wr_baseaddress = $urandom;
      ctrl_start          = 1'b1;
      run_bursts(1);
      ctrl_start = 1'b0;
    end

    // Reset in the middle of the read data phase.
    ctrl_burstcount = 4'd8;
    ctrl_start      = 1'b1;
    cyc             = 0;
    while (!(!rd_pending && beats_left > 0 && beats_left <= 5) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("mid_data_reached", (beats_left > 0 && beats_left <= 5), 1);
    do_reset();

    // Recovery: index restarts at 0 and no stale FIFO words leak out.
    ctrl_rd_baseaddress = 32'h3800_0000;
    ctrl_wr_baseaddress = 32'h3900_0000;
    ctrl_start          = 1'b1;
    run_bursts(2);
    ctrl_start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
